// File: rtl/lms_weight_update.sv
// rtl/lms_weight_update.sv - LMS coefficient engine: latch error, walk taps one per clock with saturating update
module lms_weight_update #(
  parameter int TAPS     = 4,
  parameter int DW       = 8,
  parameter int WW       = 8,
  parameter int MU_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_x,
  input  logic [DW-1:0]        in_d,
  input  logic [DW-1:0]        in_y,
  output logic [DW-1:0]        out_e,
  output logic [TAPS*WW-1:0]   out_w,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int KW = $clog2(TAPS);
  localparam int PW = 2 * DW;
  // Sum width leaves one guard bit above the wider of weight and product.
  localparam int SW = ((WW > PW) ? WW : PW) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] e_q, e_d;
  logic [DW-1:0] xl_q [TAPS];
  logic [DW-1:0] xl_d [TAPS];
  logic [WW-1:0] w_q [TAPS];
  logic [WW-1:0] w_d [TAPS];

  logic                 accept;
  logic signed [DW:0]   diff;
  logic [DW-1:0]        xk;
  logic [WW-1:0]        wk;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;
  logic signed [SW-1:0] sum;

  // Clamp a DW+1 bit difference into DW bits.
  function automatic logic [DW-1:0] sat_dw(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  // Clamp the wide weight sum into WW bits; overflow when the top bits disagree.
  function automatic logic [WW-1:0] sat_ww(input logic signed [SW-1:0] v);
    if (v[SW-1:WW-1] != {(SW-WW+1){v[SW-1]}})
      return v[SW-1] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    return v[WW-1:0];
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_UPDATE) || (state_q == S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign out_e     = e_q;
  assign accept    = in_valid && in_ready;

  // Datapath for the tap currently being visited; product floors toward -inf.
  always_comb begin
    diff  = $signed({in_d[DW-1], in_d}) - $signed({in_y[DW-1], in_y});
    xk    = xl_q[k_q];
    wk    = w_q[k_q];
    prod  = PW'($signed(e_q)) * PW'($signed(xk));
    delta = prod >>> MU_SHIFT;
    sum   = SW'(delta) + SW'($signed(wk));
  end

  // Next-state: accept shifts the delay line and latches error; UPDATE writes one tap per clock.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    e_d     = e_q;
    for (int i = 0; i < TAPS; i++) begin
      xl_d[i] = xl_q[i];
      w_d[i]  = w_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          xl_d[0] = in_x;
          for (int i = 1; i < TAPS; i++) xl_d[i] = xl_q[i-1];
          e_d     = sat_dw(diff);
          k_d     = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_d[k_q] = sat_ww(sum);
        if (k_q == KW'(TAPS - 1)) begin
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears weights and history at once so no partial update survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      e_q     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        xl_q[i] <= '0;
        w_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      e_q     <= e_d;
      for (int i = 0; i < TAPS; i++) begin
        xl_q[i] <= xl_d[i];
        w_q[i]  <= w_d[i];
      end
    end
  end

  // Flatten weights for the FIR: w[k] at bits [k*WW +: WW].
  always_comb begin
    out_w = '0;
    for (int i = 0; i < TAPS; i++) out_w[i*WW +: WW] = w_q[i];
  end

endmodule

// File: doc/lms_weight_update.md
# lms_weight_update

Adaptive-coefficient engine that sits directly downstream of the `FIR` stage in the LMS adaptive filter. For each sample it takes the FIR output `y`, the desired response `d` and the input sample `x`, and forms the error `e = d - y`. It then walks the taps one per clock applying `w[k] <= w[k] + ((e * x[n-k]) >>> MU_SHIFT)` with saturation. The updated coefficient vector is presented on a flat bus for the FIR to consume on the next sample.

## Interface
- `TAPS`, 4: number of coefficients / delay-line depth (≥ 2)
- `DW`, 8: signed width of x, d, y, e
- `WW`, 8: signed width of each weight
- `MU_SHIFT`, 3: step size μ = 2^-MU_SHIFT, applied as an arithmetic right shift
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  sample triple present
- `in_ready`  out  1  block can accept; high only in IDLE
- `in_x`  in  DW  newest input sample x[n], signed
- `in_d`  in  DW  desired response d[n], signed
- `in_y`  in  DW  FIR output y[n], signed
- `out_e`  out  DW  latched error of the current sample, signed
- `out_w`  out  TAPS*WW  weights; w[k] at bits [k*WW +: WW]
- `out_valid`  out  1  one-cycle pulse: `out_w` is final for this sample
- `busy`  out  1  high in UPDATE and DONE

## Operation
- Internal delay line `xl[0..TAPS-1]`; `xl[k]` holds x[n-k].
- Accept occurs when `in_valid && in_ready` at a rising edge. On accept:
  - shift `xl` by one, with `xl[0] <= in_x`;
  - set `out_e <= sat_DW(in_d - in_y)`, computing the difference at DW+1 bits;
  - load `k <= 0` and go to UPDATE.
- UPDATE handles one tap per clock:
  - `prod = out_e * xl[k]`, 2*DW bits signed;
  - `delta = prod >>> MU_SHIFT`, an arithmetic shift that floors toward −∞;
  - `w[k] <= sat_WW(w[k] + delta)`, summed at max(WW, 2*DW)+1 bits;
  - increment `k`. After the write of tap TAPS-1, go to DONE.
- DONE asserts `out_valid` for exactly one cycle, then returns to IDLE.
- States:
  - IDLE → UPDATE on accept; IDLE holds otherwise;
  - UPDATE → UPDATE while k < TAPS-1; UPDATE → DONE after tap TAPS-1;
  - DONE → IDLE unconditionally.
- Saturation: `sat_N` clamps to [−2^(N-1), 2^(N-1)−1]. There is no wrap-around anywhere.
- `in_valid` is ignored outside IDLE. A held `in_valid` is accepted once, on the first IDLE edge, and is accepted again on each subsequent IDLE edge while it stays high.
- `in_x`, `in_d` and `in_y` are sampled only at the accept edge. Later changes have no effect on the sample in flight.
- Weights not yet visited in UPDATE keep their old values. `out_w` is stable and complete only while `out_valid` is high or while in IDLE.

## Timing
- Reset values (asynchronous, immediate): all `w` = 0, all `xl` = 0, `out_e` = 0, `out_valid` = 0, state IDLE. This gives `in_ready` = 1 and `busy` = 0.
- `in_ready` = (state == IDLE), decoded from the registered state.
- Accept at edge T0. Tap k is written at edge T(k+1). Edge T(TAPS) enters DONE, so `out_valid` = 1 during cycle T(TAPS)..T(TAPS+1). Edge T(TAPS+1) enters IDLE.
- Throughput is one sample per TAPS+2 clocks. With TAPS=4, back-to-back accepts are 6 clocks apart.
- `rst` asserted mid-UPDATE or in DONE:
  - weights and delay line clear immediately;
  - `out_valid` drops immediately;
  - no partial update survives.
- `out_e` changes only at an accept edge or at reset.

## Test plan
- Reset: assert `rst` mid-run (even asynchronously, between edges) → outputs take their reset values with no clock edge needed. After release: `in_ready`=1, `out_w`=0, `out_e`=0, `out_valid`=0, `busy`=0.
- Single update (TAPS=4, MU_SHIFT=3): x=2, d=16, y=0 → `out_e`=16, then w=[4,0,0,0]. `out_valid` pulses at T4 for one cycle, and `in_ready` returns at T5.
- Floor rounding and history: after reset apply x=1, d=−1, y=0 → w0=−1. Next apply x=2, d=8, y=0, so `xl`=[2,1,0,0] and e=8 → w0 = −1+2 = 1, w1 = 0+1 = 1.
- Error saturation: d=127, y=−128 → `out_e`=127. d=−128, y=127 → `out_e`=−128.
- Weight saturation: x=127, d=127, y=0 for two samples. After the first, w0 = 127 (delta 2016, clamped). After the second, w0=127 and w1=127, with no wrap to negative.
- Handshake: hold `in_valid`=1 continuously with changing data → exactly one accept every 6 clocks, and each accept latches the data present at its own edge. Assert `rst` at T2 of an update → w=0 and state IDLE with no `out_valid` pulse.
